// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, misalign sequencer states and the size-to-byte-count helper.
package lsu_pkg;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    typedef enum logic [2:0] {
        IDLE,
        LD_LO,
        LD_HI,
        LD_WAIT,
        ST_SEQ,
        DONE
    } msa_state_e;
    function automatic logic [2:0] size_nb(input logic [1:0] size);
        return size == SZ_B ? 3'd1 : size == SZ_H ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/lsu_ld_align.sv
// lsu_ld_align: picks nb bytes starting at byte off of {hi, lo} and sign/zero-extends them.
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo,
    input  logic [23:0] hi,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sgn,
    output logic [31:0] result
);
    logic [31:0] sh;
    assign sh = 32'({hi, lo} >> {off, 3'b000});
    always_comb begin
        result = size == SZ_B ? {{24{sgn & sh[7]}}, sh[7:0]} :
                 size == SZ_H ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
    end
endmodule

// File: rtl/lsu_misalign_ctrl.sv
// lsu_misalign_ctrl: splits misaligned loads into word reads and misaligned stores into byte beats.
// Define MISALIGN_TRAP_EN to trap misaligned requests instead of splitting them.
module lsu_misalign_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_signed,
    input  logic              i_req_wren,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_misalign,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [31:0]       o_lsu_st_data,
    output logic [1:0]        o_lsu_size,
    output logic              o_lsu_signed,
    output logic              o_lsu_wren,
    input  logic [31:0]       i_lsu_ld_data
);
    msa_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, lo_q, ld_res;
    logic [1:0]        size_q, beat_q, last_q, next_beat;
    logic              sgn_q, cross_q, trap_q;
    logic [2:0]        nb_in;
    logic              aligned_in, cross_in, trap_in;

    assign nb_in      = size_nb(i_req_size);
    assign aligned_in = ~|(i_req_addr[1:0] & (nb_in[1:0] - 2'd1));
    assign cross_in   = ({1'b0, i_req_addr[1:0]} + nb_in) > 3'd4;
    assign next_beat  = beat_q + 2'd1;
`ifdef MISALIGN_TRAP_EN
    assign trap_in = !aligned_in;
`else
    assign trap_in = 1'b0;
`endif
    assign o_req_ready  = state == IDLE;
    assign o_lsu_signed = 1'b0;

    // the high word arrives on the wire while the low word sits in lo_q
    lsu_ld_align u_align (
        .lo    (cross_q ? lo_q : i_lsu_ld_data),
        .hi    (i_lsu_ld_data[23:0]),
        .off   (addr_q[1:0]),
        .size  (size_q),
        .sgn   (sgn_q),
        .result(ld_res)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state          <= IDLE;
            o_lsu_addr     <= '0;
            o_lsu_st_data  <= '0;
            o_lsu_size     <= '0;
            o_lsu_wren     <= 1'b0;
            o_rsp_valid    <= 1'b0;
            o_rsp_rdata    <= '0;
            o_rsp_misalign <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            lo_q           <= '0;
            size_q         <= '0;
            sgn_q          <= 1'b0;
            cross_q        <= 1'b0;
            trap_q         <= 1'b0;
            beat_q         <= '0;
            last_q         <= '0;
        end else begin
            o_rsp_valid <= 1'b0;
            o_lsu_wren  <= 1'b0;
            case (state)
                IDLE: if (i_req_valid) begin
                    addr_q  <= i_req_addr;
                    wdata_q <= i_req_wdata;
                    size_q  <= i_req_size;
                    sgn_q   <= i_req_signed;
                    cross_q <= cross_in;
                    trap_q  <= trap_in;
                    beat_q  <= '0;
                    last_q  <= aligned_in ? 2'd0 : nb_in[1:0] - 2'd1;
                    if (trap_in) begin
                        state <= LD_WAIT;
                    end else if (!i_req_wren) begin
                        o_lsu_addr <= {i_req_addr[ADDR_W-1:2], 2'b00};
                        o_lsu_size <= SZ_W;
                        state      <= LD_LO;
                    end else begin
                        o_lsu_addr    <= i_req_addr;
                        o_lsu_size    <= aligned_in ? i_req_size : SZ_B;
                        o_lsu_st_data <= aligned_in ? i_req_wdata : {24'd0, i_req_wdata[7:0]};
                        o_lsu_wren    <= 1'b1;
                        state         <= ST_SEQ;
                    end
                end
                LD_LO: begin
                    if (cross_q)
                        o_lsu_addr <= o_lsu_addr + ADDR_W'(4);
                    state <= cross_q ? LD_HI : LD_WAIT;
                end
                LD_HI: begin
                    lo_q  <= i_lsu_ld_data;
                    state <= LD_WAIT;
                end
                LD_WAIT: begin
                    o_rsp_rdata    <= trap_q ? 32'd0 : ld_res;
                    o_rsp_misalign <= trap_q;
                    o_rsp_valid    <= 1'b1;
                    state          <= DONE;
                end
                ST_SEQ: begin
                    if (beat_q == last_q) begin
                        o_rsp_rdata    <= '0;
                        o_rsp_misalign <= 1'b0;
                        o_rsp_valid    <= 1'b1;
                        state          <= DONE;
                    end else begin
                        beat_q        <= next_beat;
                        o_lsu_addr    <= addr_q + {{(ADDR_W-2){1'b0}}, next_beat};
                        o_lsu_st_data <= {24'd0, wdata_q[{next_beat, 3'b000} +: 8]};
                        o_lsu_wren    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_misalign_ctrl.sv
// tb_lsu_misalign_ctrl: random and directed requests against a byte-memory model of lsu and a byte-level reference.
module tb_lsu_misalign_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic [1:0]  i_req_size = '0;
    logic        i_req_signed = 1'b0;
    logic        i_req_wren = 1'b0;
    logic        o_rsp_valid, o_rsp_misalign, o_lsu_signed, o_lsu_wren;
    logic [31:0] o_rsp_rdata, o_lsu_addr, o_lsu_st_data;
    logic [1:0]  o_lsu_size;
    logic [31:0] lsu_rd = '0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } beat_t;

    logic [7:0] lsu_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];
    beat_t      wq[$];
    int         n_chk = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    lsu_misalign_ctrl #(.ADDR_W(32)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_addr    (i_req_addr),
        .i_req_wdata   (i_req_wdata),
        .i_req_size    (i_req_size),
        .i_req_signed  (i_req_signed),
        .i_req_wren    (i_req_wren),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_rdata   (o_rsp_rdata),
        .o_rsp_misalign(o_rsp_misalign),
        .o_lsu_addr    (o_lsu_addr),
        .o_lsu_st_data (o_lsu_st_data),
        .o_lsu_size    (o_lsu_size),
        .o_lsu_signed  (o_lsu_signed),
        .o_lsu_wren    (o_lsu_wren),
        .i_lsu_ld_data (lsu_rd)
    );

    function automatic int nbytes(input logic [1:0] s);
        return s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return lsu_mem.exists(a) ? lsu_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    // lsu stand-in: read data one cycle after the address, writes land at the edge
    always @(posedge clk) begin
        lsu_rd <= {mem_byte(o_lsu_addr + 32'd3), mem_byte(o_lsu_addr + 32'd2),
                   mem_byte(o_lsu_addr + 32'd1), mem_byte(o_lsu_addr)};
        if (o_lsu_wren) begin
            wq.push_back('{o_lsu_addr, o_lsu_st_data, o_lsu_size});
            for (int k = 0; k < nbytes(o_lsu_size); k++)
                lsu_mem[o_lsu_addr + 32'(k)] = o_lsu_st_data[8*k +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic sg);
        int          nb = nbytes(s);
        logic [31:0] v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_byte(a + 32'(k));
        if (sg && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        return v;
    endfunction

    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input logic sg, input logic we);
        int          nb = nbytes(s);
        int          off = int'(a[1:0]);
        bit          al = (off % nb) == 0;
        bit          cr = off + nb > 4;
        int          beats = we ? (al ? 1 : nb) : 0;
        int          exp_lat = we ? 1 + beats : (cr ? 4 : 3);
        int          lat = 0;
        logic [31:0] exp_rd = we ? 32'd0 : ref_load(a, s, sg);
        if (we) for (int k = 0; k < nb; k++) ref_mem[a + 32'(k)] = d[8*k +: 8];
        for (int i = 0; i < 20 && !o_req_ready; i++) @(negedge clk);
        check("ready_before_req", 32'(o_req_ready), 32'd1);
        i_req_valid  = 1'b1;
        i_req_addr   = a;
        i_req_wdata  = d;
        i_req_size   = s;
        i_req_signed = sg;
        i_req_wren   = we;
        @(posedge clk);
        @(negedge clk);
        wq.delete();
        for (int c = 1; c <= 20; c++) begin
            if (!we && c == 1) check("ld_lo_addr", o_lsu_addr, {a[31:2], 2'b00});
            if (!we && c == 2 && cr) check("ld_hi_addr", o_lsu_addr, {a[31:2], 2'b00} + 32'd4);
            if (o_rsp_valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_rdata", o_rsp_rdata, exp_rd);
        check("rsp_misalign", 32'(o_rsp_misalign), 32'd0);
        check("ready_in_done", 32'(o_req_ready), 32'd0);
        check("beat_count", 32'(wq.size()), 32'(beats));
        if (we && wq.size() == beats) begin
            for (int k = 0; k < beats; k++) begin
                check("st_addr", wq[k].a, a + 32'(k));
                check("st_size", 32'(wq[k].s), al ? 32'(s) : 32'd0);
                check("st_data", al ? wq[k].d : 32'(wq[k].d[7:0]), al ? d : 32'(d[8*k +: 8]));
            end
        end
        @(negedge clk);
        check("rsp_pulse_end", 32'(o_rsp_valid), 32'd0);
        check("ready_after_done", 32'(o_req_ready), 32'd1);
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_rdata", o_rsp_rdata, 32'd0);
        check("rst_lsu_addr", o_lsu_addr, 32'd0);
        check("rst_lsu_wren", 32'(o_lsu_wren), 32'd0);
        check("lsu_signed", 32'(o_lsu_signed), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 1'b1);
        do_req(32'h10, 32'h0, 2'b10, 1'b0, 1'b0);
        check("lw10_const", o_rsp_rdata, 32'hDEADBEEF);
        do_req(32'h10, 32'h44332211, 2'b10, 1'b0, 1'b1);
        do_req(32'h14, 32'h88776655, 2'b10, 1'b0, 1'b1);
        do_req(32'h13, 32'h0, 2'b10, 1'b0, 1'b0);
        check("lw13_const", o_rsp_rdata, 32'h77665544);
        do_req(32'h17, 32'h0, 2'b00, 1'b1, 1'b0);
        check("lb17_signed", o_rsp_rdata, 32'hFFFFFF88);
        do_req(32'h17, 32'h0, 2'b00, 1'b0, 1'b0);
        check("lb17_unsigned", o_rsp_rdata, 32'h00000088);
        do_req(32'h21, 32'hCAFEF00D, 2'b10, 1'b0, 1'b1);
        do_req(32'h21, 32'h0, 2'b10, 1'b0, 1'b0);
        check("lw21_const", o_rsp_rdata, 32'hCAFEF00D);

        // reset while the high word of a crossing load is on the bus
        i_req_valid = 1'b1;
        i_req_addr  = 32'h13;
        i_req_size  = 2'b10;
        i_req_wren  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        i_req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_ld_hi_addr", o_lsu_addr, 32'h14);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(o_req_ready), 32'd1);
        check("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("abort_wren", 32'(o_lsu_wren), 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= o_rsp_valid;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);

        do_req(32'hFFFF_FFFD, 32'h0, 2'b10, 1'b1, 1'b0);
        do_req(32'hFFFF_FFFE, 32'hA1B2C3D4, 2'b10, 1'b0, 1'b1);
        do_req(32'hFFFF_FFFF, 32'h0, 2'b01, 1'b1, 1'b0);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
            do_req(a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
